// File: rtl/pw_attempt_sequencer_if.sv
// Host-side command/status bundle of the password-lock attempt sequencer.
// The host drives the request; the sequencer returns status and results.
interface pw_attempt_sequencer_if #(
    parameter int CHAR_W    = 8,
    parameter int MAX_FAILS = 3
);
    localparam int FC_W = $clog2(MAX_FAILS + 1);

    logic              start;
    logic [CHAR_W-1:0] cand_char;
    logic              busy;
    logic              done;
    logic              result_open;
    logic              result_wrong;
    logic              result_tmo;
    logic              locked_out;
    logic [FC_W-1:0]   fail_count;

    modport master (
        output start, cand_char,
        input  busy, done, result_open, result_wrong, result_tmo,
               locked_out, fail_count
    );

    modport slave (
        input  start, cand_char,
        output busy, done, result_open, result_wrong, result_tmo,
               locked_out, fail_count
    );
endinterface

// File: rtl/pw_attempt_sequencer.sv
// Sequences one single-character unlock attempt per accepted request:
// lock reset, enter press with the candidate, then wait for the verdict.
// Tracks consecutive failures and enforces a timed lockout.
module pw_attempt_sequencer #(
    parameter int CHAR_W         = 8,
    parameter int RST_CYCLES     = 2,
    parameter int ENTER_CYCLES   = 3,
    parameter int TIMEOUT        = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pw_attempt_sequencer_if.slave  host,
    output logic                   o_lock_rst_n,
    output logic [CHAR_W-1:0]      o_lock_char,
    output logic                   o_lock_enter,
    input  logic                   i_lock_open,
    input  logic                   i_lock_wrong
);
    localparam int FC_W    = $clog2(MAX_FAILS + 1);
    localparam int MAX_A   = (RST_CYCLES > ENTER_CYCLES) ? RST_CYCLES : ENTER_CYCLES;
    localparam int MAX_B   = (TIMEOUT > LOCKOUT_CYCLES) ? TIMEOUT : LOCKOUT_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENTER_LAST = CNT_W'(ENTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0]  FAIL_MAX   = FC_W'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_PRESS,
        S_WAIT,
        S_REPORT,
        S_LOCKOUT
    } state_t;

    // Verdict encoding: {open, wrong, timeout}
    localparam logic [2:0] K_OPEN  = 3'b100;
    localparam logic [2:0] K_WRONG = 3'b010;
    localparam logic [2:0] K_TMO   = 3'b001;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_kind;
    logic [2:0]        r_res;
    logic [FC_W-1:0]   r_fail;
    logic [CHAR_W-1:0] r_lock_char;
    logic              r_busy;
    logic              r_done;
    logic              r_locked_out;
    logic              r_lock_rst_n;
    logic              r_lock_enter;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        w_kind_nxt;
    logic [2:0]        w_res_nxt;
    logic [FC_W-1:0]   w_fail_nxt;
    logic [FC_W-1:0]   w_fail_inc;
    logic [CHAR_W-1:0] w_char_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_locked_out_nxt;
    logic              w_lock_rst_n_nxt;
    logic              w_lock_enter_nxt;

    // State, phase counter, results and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_kind       <= '0;
            r_res        <= '0;
            r_fail       <= '0;
            r_lock_char  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_locked_out <= 1'b0;
            r_lock_rst_n <= 1'b0;
            r_lock_enter <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_kind       <= w_kind_nxt;
            r_res        <= w_res_nxt;
            r_fail       <= w_fail_nxt;
            r_lock_char  <= w_char_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_locked_out <= w_locked_out_nxt;
            r_lock_rst_n <= w_lock_rst_n_nxt;
            r_lock_enter <= w_lock_enter_nxt;
        end
    end

    // Next-state, phase timing and next output values.
    // Status outputs decode the current state, so they trail the state by one
    // cycle; results and fail_count are written on leaving REPORT so they
    // change on the same edge that raises done.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_kind_nxt  = r_kind;
        w_res_nxt   = r_res;
        w_fail_nxt  = r_fail;
        w_char_nxt  = r_lock_char;
        w_fail_inc  = (r_fail == FAIL_MAX) ? r_fail : r_fail + FC_W'(1);

        w_busy_nxt       = (r_state != S_IDLE);
        w_done_nxt       = (r_state == S_REPORT);
        w_locked_out_nxt = (r_state == S_LOCKOUT);
        w_lock_rst_n_nxt = (r_state != S_RST);
        w_lock_enter_nxt = (r_state == S_PRESS);

        case (r_state)
            S_IDLE: begin
                if (host.start) begin
                    w_state_nxt = S_RST;
                    w_cnt_nxt   = '0;
                    w_char_nxt  = host.cand_char;
                    w_res_nxt   = '0;
                end
            end
            S_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_PRESS;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PRESS: begin
                if (r_cnt == ENTER_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (i_lock_open) begin
                    w_kind_nxt  = K_OPEN;
                    w_state_nxt = S_REPORT;
                    w_cnt_nxt   = '0;
                end else if (i_lock_wrong) begin
                    w_kind_nxt  = K_WRONG;
                    w_state_nxt = S_REPORT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TMO_LAST) begin
                    w_kind_nxt  = K_TMO;
                    w_state_nxt = S_REPORT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_REPORT: begin
                w_res_nxt = r_kind;
                w_cnt_nxt = '0;
                if (r_kind[2]) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_fail_nxt  = w_fail_inc;
                    w_state_nxt = (w_fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_fail_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign host.busy         = r_busy;
    assign host.done         = r_done;
    assign host.result_open  = r_res[2];
    assign host.result_wrong = r_res[1];
    assign host.result_tmo   = r_res[0];
    assign host.locked_out   = r_locked_out;
    assign host.fail_count   = r_fail;
    assign o_lock_rst_n      = r_lock_rst_n;
    assign o_lock_char       = r_lock_char;
    assign o_lock_enter      = r_lock_enter;
endmodule

// File: tb/tb_pw_attempt_sequencer.sv
// Directed bench for pw_attempt_sequencer driving a small password-lock model
// (password 0x48) with default parameters.
module tb_pw_attempt_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cand = 8'h00;
    logic       mute = 1'b0;
    logic       both = 1'b0;

    logic       lock_rst_n;
    logic [7:0] lock_char;
    logic       lock_enter;
    logic       lk_open = 1'b0;
    logic       lk_wrong = 1'b0;
    logic       lock_open_in;
    logic       lock_wrong_in;

    int vectors = 0;
    int miscompares = 0;

    pw_attempt_sequencer_if #(.CHAR_W(8), .MAX_FAILS(3)) h ();

    assign h.start       = start;
    assign h.cand_char   = cand;
    assign lock_open_in  = (lk_open | both) & ~mute;
    assign lock_wrong_in = (lk_wrong | both) & ~mute;

    pw_attempt_sequencer #(
        .CHAR_W(8), .RST_CYCLES(2), .ENTER_CYCLES(3),
        .TIMEOUT(16), .MAX_FAILS(3), .LOCKOUT_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .host(h),
        .o_lock_rst_n(lock_rst_n),
        .o_lock_char(lock_char),
        .o_lock_enter(lock_enter),
        .i_lock_open(lock_open_in),
        .i_lock_wrong(lock_wrong_in)
    );

    always #5 clk = ~clk;

    // Lock model: cleared while reset low, latches open/wrong on enter.
    always @(posedge clk) begin
        if (!lock_rst_n) begin
            lk_open  <= 1'b0;
            lk_wrong <= 1'b0;
        end else if (lock_enter) begin
            if (lock_char == 8'h48) lk_open  <= 1'b1;
            else                    lk_wrong <= 1'b1;
        end
    end

    typedef struct {
        logic        start;
        logic [7:0]  cand;
        logic [17:0] exp;
    } vec_t;

    function automatic logic [17:0] pk(input logic busy, input logic done,
                                       input logic ro, input logic rw, input logic rt,
                                       input logic lo, input logic [1:0] fc,
                                       input logic lrst, input logic [7:0] ch,
                                       input logic en);
        return {busy, done, ro, rw, rt, lo, fc, lrst, ch, en};
    endfunction

    function automatic logic [17:0] obs();
        return {h.busy, h.done, h.result_open, h.result_wrong, h.result_tmo,
                h.locked_out, h.fail_count, lock_rst_n, lock_char, lock_enter};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_attempt(input string nm, input logic [7:0] c, input int exp_lat,
                               input logic [2:0] exp_res, input logic [1:0] exp_fc);
        int n;
        int lo_cnt;
        int en_cnt;
        bit got;
        n = 0; lo_cnt = 0; en_cnt = 0; got = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cand  = c;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (!lock_rst_n) lo_cnt++;
            if (lock_enter)  en_cnt++;
            if (h.done)      got = 1'b1;
        end
        chk({nm, "_done_seen"},    32'(got), 32'(1));
        chk({nm, "_latency"},      32'(n - 1), 32'(exp_lat));
        chk({nm, "_rst_cycles"},   32'(lo_cnt), 32'(2));
        chk({nm, "_enter_cycles"}, 32'(en_cnt), 32'(3));
        chk({nm, "_result"},       32'({h.result_open, h.result_wrong, h.result_tmo}), 32'(exp_res));
        chk({nm, "_fail_count"},   32'(h.fail_count), 32'(exp_fc));
        chk({nm, "_lock_char"},    32'(lock_char), 32'(c));
    endtask

    initial begin
        vec_t tbl[9];
        int   lo_n;
        int   n;
        bit   rst_seen;
        bit   busy_drop;
        bit   ended;
        bit   found;
        bit   dseen;
        bit   got;

        // One successful attempt, cycle by cycle; cand changes mid-attempt.
        tbl[0] = '{1'b1, 8'h48, pk(0,0,0,0,0,0,2'd0,1,8'h48,0)};
        tbl[1] = '{1'b0, 8'h41, pk(1,0,0,0,0,0,2'd0,0,8'h48,0)};
        tbl[2] = '{1'b0, 8'h41, pk(1,0,0,0,0,0,2'd0,0,8'h48,0)};
        tbl[3] = '{1'b0, 8'h41, pk(1,0,0,0,0,0,2'd0,1,8'h48,1)};
        tbl[4] = '{1'b0, 8'h41, pk(1,0,0,0,0,0,2'd0,1,8'h48,1)};
        tbl[5] = '{1'b0, 8'h41, pk(1,0,0,0,0,0,2'd0,1,8'h48,1)};
        tbl[6] = '{1'b0, 8'h41, pk(1,0,0,0,0,0,2'd0,1,8'h48,0)};
        tbl[7] = '{1'b0, 8'h41, pk(1,1,1,0,0,0,2'd0,1,8'h48,0)};
        tbl[8] = '{1'b0, 8'h41, pk(0,0,1,0,0,0,2'd0,1,8'h48,0)};

        repeat (3) @(negedge clk);
        chk("reset_state", 32'(obs()), 32'(pk(0,0,0,0,0,0,2'd0,0,8'h00,0)));
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'(obs()), 32'(pk(0,0,0,0,0,0,2'd0,1,8'h00,0)));

        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start;
            cand  = tbl[i].cand;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
        end
        start = 1'b0;

        // Three wrong attempts trigger a 32-cycle lockout.
        run_attempt("wrong1", 8'h41, 7, 3'b010, 2'd1);
        run_attempt("wrong2", 8'h41, 7, 3'b010, 2'd2);
        run_attempt("wrong3", 8'h41, 7, 3'b010, 2'd3);
        lo_n = 0; rst_seen = 1'b0; busy_drop = 1'b0; ended = 1'b0;
        for (int i = 0; i < 100 && !ended; i++) begin
            @(negedge clk);
            if (h.locked_out) begin
                lo_n++;
                if (!h.busy)      busy_drop = 1'b1;
                if (!lock_rst_n)  rst_seen = 1'b1;
                if (lo_n == 10) begin start = 1'b1; cand = 8'h48; end
                if (lo_n == 13) start = 1'b0;
            end else begin
                ended = 1'b1;
            end
        end
        start = 1'b0;
        chk("lockout_ended",        32'(ended), 32'(1));
        chk("lockout_cycles",       32'(lo_n), 32'(32));
        chk("lockout_start_ignored", 32'(rst_seen), 32'(0));
        chk("lockout_busy_held",    32'(busy_drop), 32'(0));
        chk("lockout_exit_fc",      32'(h.fail_count), 32'(0));
        chk("lockout_exit_busy",    32'(h.busy), 32'(0));
        run_attempt("after_lockout", 8'h48, 7, 3'b100, 2'd0);

        // Silent lock: timeout after 16 WAIT cycles.
        mute = 1'b1;
        run_attempt("timeout", 8'h41, 22, 3'b001, 2'd1);
        mute = 1'b0;

        // Reset while in PRESS aborts the attempt.
        found = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cand  = 8'h41;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (lock_enter) found = 1'b1;
        end
        chk("rstmid_reached_press", 32'(found), 32'(1));
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstmid_outputs", 32'(obs()), 32'(pk(0,0,0,0,0,0,2'd0,0,8'h00,0)));
        dseen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (h.done) dseen = 1'b1;
        end
        chk("rstmid_no_done", 32'(dseen), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid_idle", 32'(obs()), 32'(pk(0,0,0,0,0,0,2'd0,1,8'h00,0)));

        // open and wrong together: open wins.
        both = 1'b1;
        run_attempt("both", 8'h41, 7, 3'b100, 2'd0);
        both = 1'b0;

        // Two wrong then correct: count returns to 0, no lockout.
        run_attempt("pre_wrong1", 8'h41, 7, 3'b010, 2'd1);
        run_attempt("pre_wrong2", 8'h41, 7, 3'b010, 2'd2);
        run_attempt("recover",    8'h48, 7, 3'b100, 2'd0);
        @(negedge clk);
        chk("recover_no_lockout", 32'(obs()), 32'(pk(0,0,1,0,0,0,2'd0,1,8'h48,0)));

        // start held high: back-to-back attempts with one idle cycle.
        @(negedge clk);
        start = 1'b1;
        cand  = 8'h48;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 3) cand = 8'h41;
            if (h.done) got = 1'b1;
        end
        chk("b2b_first_latency", 32'(n - 1), 32'(7));
        chk("b2b_first_result",  32'({h.result_open, h.result_wrong, h.result_tmo}), 32'(3'b100));
        chk("b2b_first_char",    32'(lock_char), 32'(8'h48));
        @(negedge clk);
        chk("b2b_gap", 32'({h.busy, h.done}), 32'(2'b00));
        @(negedge clk);
        chk("b2b_busy_again", 32'(h.busy), 32'(1));
        n = 1; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (h.done) got = 1'b1;
        end
        start = 1'b0;
        chk("b2b_second_latency", 32'(n), 32'(7));
        chk("b2b_second_result",  32'({h.result_open, h.result_wrong, h.result_tmo}), 32'(3'b010));
        chk("b2b_second_fc",      32'(h.fail_count), 32'(1));
        chk("b2b_second_char",    32'(lock_char), 32'(8'h41));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
